// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART data-path FIFOs.
package uart_pkg;

    localparam int UART_FIFO_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Bits needed to address 'value' entries; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: register array with a synchronous write port and an asynchronous read port.
module uart_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately left out of reset; valid words are tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART FIFO with level, programmable thresholds, sticky error flags, flush and FWFT mode.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int  DATA_WIDTH = UART_FIFO_WIDTH,
    parameter int  DEPTH      = UART_FIFO_DEPTH,
    parameter int  FWFT       = FIFO_MODE_REG,
    localparam int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level,
    input  logic [ADDR_WIDTH:0]   af_th,
    input  logic [ADDR_WIDTH:0]   ae_th,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int                    LW         = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [LW-1:0]         FULL_LEVEL = LW'(DEPTH);

    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [LW-1:0]         level_nxt;
    logic [DATA_WIDTH-1:0] mem_r_data;
    logic                  wr_ok;
    logic                  rd_ok;

    // Accept decisions look only at the registered flags, so a write into a full FIFO is refused even alongside a read.
    assign wr_ok = w_en & ~full  & ~flush;
    assign rd_ok = r_en & ~empty & ~flush;

    uart_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .w_en  (wr_ok),
        .w_addr(w_ptr),
        .w_data(w_data),
        .r_addr(r_ptr),
        .r_data(mem_r_data)
    );

    // NOTE: level_nxt is assigned a default first so no path through this block can infer a latch.
    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else if (wr_ok && !rd_ok) begin
            level_nxt = level + LW'(1);
        end else if (rd_ok && !wr_ok) begin
            level_nxt = level - LW'(1);
        end
    end

    // NOTE: state updates use <= so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (flush) begin
                w_ptr <= '0;
                r_ptr <= '0;
            end else begin
                if (wr_ok) begin
                    w_ptr <= (w_ptr == LAST_ADDR) ? '0 : w_ptr + ADDR_WIDTH'(1);
                end
                if (rd_ok) begin
                    r_ptr <= (r_ptr == LAST_ADDR) ? '0 : r_ptr + ADDR_WIDTH'(1);
                end
            end
            level        <= level_nxt;
            full         <= (level_nxt == FULL_LEVEL);
            empty        <= (level_nxt == '0);
            almost_full  <= (level_nxt >= af_th);
            almost_empty <= (level_nxt <= ae_th);
            // A new error event wins over a simultaneous clear.
            overflow     <= (w_en & full  & ~flush) | (overflow  & ~err_clr);
            underflow    <= (r_en & empty & ~flush) | (underflow & ~err_clr);
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign r_valid = ~empty;
        assign r_data  = empty ? '0 : mem_r_data;
    end else begin : g_reg
        // A flush forces rd_ok low, which also drops r_valid on the same edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= rd_ok;
                if (rd_ok) begin
                    r_data <= mem_r_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Bench for uart_sync_fifo: three instances (registered D16, FWFT D16, registered D12) against a sequence-count model.
module tb_uart_sync_fifo;
    import uart_pkg::*;

    localparam int N    = 3;
    localparam int HMAX = 8192;

    logic clk;
    logic rst;

    logic       flush   [N];
    logic       w_en    [N];
    logic [7:0] w_data  [N];
    logic       r_en    [N];
    logic       err_clr [N];
    logic [4:0] af_th   [N];
    logic [4:0] ae_th   [N];

    logic [7:0] r_data       [N];
    logic       r_valid      [N];
    logic       full         [N];
    logic       empty        [N];
    logic [4:0] level        [N];
    logic       almost_full  [N];
    logic       almost_empty [N];
    logic       overflow     [N];
    logic       underflow    [N];

    // Model: every accepted write gets a sequence number; the FIFO holds numbers rd_cnt .. wr_cnt-1.
    int         wr_cnt   [N];
    int         rd_cnt   [N];
    logic [7:0] hist     [N][HMAX];
    logic [7:0] rdata_m  [N];
    logic       rvalid_m [N];
    logic       ovf_m    [N];
    logic       unf_m    [N];
    logic [4:0] af_s     [N];
    logic [4:0] ae_s     [N];
    bit         edged    [N];

    int checks = 0;
    int errors = 0;

    uart_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(FIFO_MODE_REG)) u_reg16 (
        .clk(clk), .rst(rst), .flush(flush[0]), .w_en(w_en[0]), .w_data(w_data[0]),
        .r_en(r_en[0]), .r_data(r_data[0]), .r_valid(r_valid[0]), .full(full[0]),
        .empty(empty[0]), .level(level[0]), .af_th(af_th[0]), .ae_th(ae_th[0]),
        .almost_full(almost_full[0]), .almost_empty(almost_empty[0]),
        .overflow(overflow[0]), .underflow(underflow[0]), .err_clr(err_clr[0])
    );

    uart_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(FIFO_MODE_FWFT)) u_fwft16 (
        .clk(clk), .rst(rst), .flush(flush[1]), .w_en(w_en[1]), .w_data(w_data[1]),
        .r_en(r_en[1]), .r_data(r_data[1]), .r_valid(r_valid[1]), .full(full[1]),
        .empty(empty[1]), .level(level[1]), .af_th(af_th[1]), .ae_th(ae_th[1]),
        .almost_full(almost_full[1]), .almost_empty(almost_empty[1]),
        .overflow(overflow[1]), .underflow(underflow[1]), .err_clr(err_clr[1])
    );

    uart_sync_fifo #(.DATA_WIDTH(8), .DEPTH(12), .FWFT(FIFO_MODE_REG)) u_reg12 (
        .clk(clk), .rst(rst), .flush(flush[2]), .w_en(w_en[2]), .w_data(w_data[2]),
        .r_en(r_en[2]), .r_data(r_data[2]), .r_valid(r_valid[2]), .full(full[2]),
        .empty(empty[2]), .level(level[2]), .af_th(af_th[2]), .ae_th(ae_th[2]),
        .almost_full(almost_full[2]), .almost_empty(almost_empty[2]),
        .overflow(overflow[2]), .underflow(underflow[2]), .err_clr(err_clr[2])
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    function automatic int depth_of(input int i);
        return (i == 2) ? 12 : 16;
    endfunction

    function automatic bit is_fwft(input int i);
        return (i == 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            wr_cnt[i]   = 0;
            rd_cnt[i]   = 0;
            rdata_m[i]  = 8'h00;
            rvalid_m[i] = 1'b0;
            ovf_m[i]    = 1'b0;
            unf_m[i]    = 1'b0;
            edged[i]    = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        int lvl;
        bit is_full;
        bit is_empty;
        bit ovf_set;
        bit unf_set;
        lvl      = wr_cnt[i] - rd_cnt[i];
        is_full  = (lvl == depth_of(i));
        is_empty = (lvl == 0);
        ovf_set  = w_en[i] && is_full  && !flush[i];
        unf_set  = r_en[i] && is_empty && !flush[i];
        rvalid_m[i] = 1'b0;
        if (flush[i]) begin
            rd_cnt[i] = wr_cnt[i];
        end else begin
            if (r_en[i] && !is_empty) begin
                rdata_m[i]  = hist[i][rd_cnt[i] % HMAX];
                rvalid_m[i] = 1'b1;
                rd_cnt[i]++;
            end
            if (w_en[i] && !is_full) begin
                hist[i][wr_cnt[i] % HMAX] = w_data[i];
                wr_cnt[i]++;
            end
        end
        ovf_m[i] = ovf_set || (ovf_m[i] && !err_clr[i]);
        unf_m[i] = unf_set || (unf_m[i] && !err_clr[i]);
        af_s[i]  = af_th[i];
        ae_s[i]  = ae_th[i];
        edged[i] = 1'b1;
    endtask

    task automatic check_outputs(input int i);
        int         lvl;
        logic       exp_af;
        logic       exp_ae;
        logic       exp_valid;
        logic [7:0] exp_data;
        lvl    = wr_cnt[i] - rd_cnt[i];
        exp_af = edged[i] ? (lvl >= int'(af_s[i])) : 1'b0;
        exp_ae = edged[i] ? (lvl <= int'(ae_s[i])) : 1'b1;
        if (is_fwft(i)) begin
            exp_valid = (lvl != 0);
            exp_data  = (lvl != 0) ? hist[i][rd_cnt[i] % HMAX] : 8'h00;
        end else begin
            exp_valid = rvalid_m[i];
            exp_data  = rdata_m[i];
        end
        check($sformatf("u%0d.level", i),        32'(level[i]),        32'(lvl));
        check($sformatf("u%0d.full", i),         32'(full[i]),         32'(lvl == depth_of(i)));
        check($sformatf("u%0d.empty", i),        32'(empty[i]),        32'(lvl == 0));
        check($sformatf("u%0d.almost_full", i),  32'(almost_full[i]),  32'(exp_af));
        check($sformatf("u%0d.almost_empty", i), 32'(almost_empty[i]), 32'(exp_ae));
        check($sformatf("u%0d.overflow", i),     32'(overflow[i]),     32'(ovf_m[i]));
        check($sformatf("u%0d.underflow", i),    32'(underflow[i]),    32'(unf_m[i]));
        check($sformatf("u%0d.r_valid", i),      32'(r_valid[i]),      32'(exp_valid));
        check($sformatf("u%0d.r_data", i),       32'(r_data[i]),       32'(exp_data));
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < N; i++) check_outputs(i);
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) begin
            flush[i]   = 1'b0;
            w_en[i]    = 1'b0;
            r_en[i]    = 1'b0;
            err_clr[i] = 1'b0;
            w_data[i]  = 8'h00;
        end
    endtask

    task automatic random_phase(input int i, input int n_cycles);
        for (int c = 0; c < n_cycles; c++) begin
            int wr_pct;
            wr_pct     = ((c / 40) % 2 == 0) ? 70 : 30;
            w_en[i]    = ($urandom_range(0, 99) < wr_pct);
            r_en[i]    = ($urandom_range(0, 99) < 100 - wr_pct);
            flush[i]   = ($urandom_range(0, 99) < 2);
            err_clr[i] = ($urandom_range(0, 99) < 6);
            w_data[i]  = 8'($urandom);
            if (c % 37 == 0) begin
                af_th[i] = 5'($urandom_range(0, 20));
                ae_th[i] = 5'($urandom_range(0, 20));
            end
            cycle();
        end
        idle();
        af_th[i] = 5'd12;
        ae_th[i] = 5'd3;
        cycle();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        idle();
        for (int i = 0; i < N; i++) begin
            af_th[i] = 5'd12;
            ae_th[i] = 5'd3;
        end
        model_reset();
        #3;
        for (int i = 0; i < N; i++) check_outputs(i);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fill the registered D16 instance with 0x00..0x0F.
        for (int k = 0; k < 16; k++) begin
            w_en[0]   = 1'b1;
            w_data[0] = 8'(k);
            cycle();
        end
        idle();
        check("fill_level", 32'(level[0]), 32'd16);
        check("fill_full",  32'(full[0]),  32'd1);
        check("fill_af",    32'(almost_full[0]), 32'd1);

        // Overflow is sticky, clears on err_clr, and a new overflow beats a clear.
        w_en[0]   = 1'b1;
        w_data[0] = 8'hAA;
        cycle();
        idle();
        check("ovf_set", 32'(overflow[0]), 32'd1);
        check("ovf_drop_level", 32'(level[0]), 32'd16);
        cycle();
        check("ovf_sticky", 32'(overflow[0]), 32'd1);
        err_clr[0] = 1'b1;
        cycle();
        idle();
        check("ovf_clr", 32'(overflow[0]), 32'd0);
        err_clr[0] = 1'b1;
        w_en[0]    = 1'b1;
        cycle();
        idle();
        check("ovf_set_beats_clr", 32'(overflow[0]), 32'd1);
        err_clr[0] = 1'b1;
        cycle();
        idle();

        // Registered-read drain: one-cycle r_valid pulse per word, in write order.
        for (int k = 0; k < 16; k++) begin
            r_en[0] = 1'b1;
            cycle();
            check($sformatf("drain_data_%0d", k),  32'(r_data[0]),  32'(k));
            check($sformatf("drain_valid_%0d", k), 32'(r_valid[0]), 32'd1);
        end
        idle();
        cycle();
        check("drain_valid_drop", 32'(r_valid[0]), 32'd0);
        r_en[0] = 1'b1;
        cycle();
        idle();
        check("unf_set", 32'(underflow[0]), 32'd1);
        check("unf_data_hold", 32'(r_data[0]), 32'h0F);
        check("unf_valid", 32'(r_valid[0]), 32'd0);
        err_clr[0] = 1'b1;
        cycle();
        idle();

        // Threshold edge values on an empty FIFO, then with one word.
        af_th[0] = 5'd0;
        ae_th[0] = 5'd16;
        cycle();
        check("af_th0", 32'(almost_full[0]),  32'd1);
        check("ae_thD", 32'(almost_empty[0]), 32'd1);
        w_en[0]   = 1'b1;
        w_data[0] = 8'h33;
        cycle();
        idle();
        check("af_th0_l1", 32'(almost_full[0]),  32'd1);
        check("ae_thD_l1", 32'(almost_empty[0]), 32'd1);
        af_th[0] = 5'd12;
        ae_th[0] = 5'd3;
        flush[0] = 1'b1;
        cycle();
        idle();

        // FWFT: word shows without r_en the cycle after the write; r_en pops it.
        w_en[1]   = 1'b1;
        w_data[1] = 8'h5A;
        cycle();
        idle();
        check("fwft_valid", 32'(r_valid[1]), 32'd1);
        check("fwft_data",  32'(r_data[1]),  32'h5A);
        r_en[1] = 1'b1;
        cycle();
        idle();
        check("fwft_pop_valid", 32'(r_valid[1]), 32'd0);

        // DEPTH 12: hold level 5 under simultaneous read/write so the pointers wrap several times.
        for (int k = 0; k < 5; k++) begin
            w_en[2]   = 1'b1;
            w_data[2] = 8'($urandom);
            cycle();
        end
        for (int k = 0; k < 40; k++) begin
            w_en[2]   = 1'b1;
            r_en[2]   = 1'b1;
            w_data[2] = 8'($urandom);
            cycle();
            check($sformatf("d12_level_%0d", k), 32'(level[2]), 32'd5);
        end
        idle();
        cycle();

        for (int i = 0; i < N; i++) random_phase(i, 240);

        // Flush at level 7 with w_en and r_en also high: nothing accepted, nothing flagged.
        flush[0]   = 1'b1;
        err_clr[0] = 1'b1;
        cycle();
        idle();
        for (int k = 0; k < 7; k++) begin
            w_en[0]   = 1'b1;
            w_data[0] = 8'($urandom);
            cycle();
        end
        idle();
        check("pre_flush_level", 32'(level[0]), 32'd7);
        flush[0] = 1'b1;
        w_en[0]  = 1'b1;
        r_en[0]  = 1'b1;
        cycle();
        idle();
        check("flush_level", 32'(level[0]),     32'd0);
        check("flush_empty", 32'(empty[0]),     32'd1);
        check("flush_ovf",   32'(overflow[0]),  32'd0);
        check("flush_unf",   32'(underflow[0]), 32'd0);
        check("flush_valid", 32'(r_valid[0]),   32'd0);

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 4; k++) begin
            w_en[0]   = 1'b1;
            r_en[0]   = (k > 1);
            w_data[0] = 8'($urandom);
            w_en[1]   = 1'b1;
            w_data[1] = 8'($urandom);
            cycle();
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < N; i++) check_outputs(i);
        check("arst_level", 32'(level[0]), 32'd0);
        check("arst_fwft_valid", 32'(r_valid[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        cycle();
        w_en[0]   = 1'b1;
        w_data[0] = 8'hC3;
        cycle();
        idle();
        r_en[0] = 1'b1;
        cycle();
        idle();
        check("post_rst_data", 32'(r_data[0]), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_sync_fifo.md
Name: uart_sync_fifo

Overview:
- Single-clock, parametrised FIFO for the UART TX/RX data paths.
- Successor to the dual-clock UART FIFO, used where the UART and its bus interface share one clock.
- Adds over the previous generation:
  - fill level output
  - programmable almost-full / almost-empty thresholds
  - sticky overflow / underflow error flags
  - synchronous flush
  - non-power-of-two depth
  - selectable first-word-fall-through (FWFT) read mode

Parameters:
- DATA_WIDTH, 8, width of one FIFO word.
- DEPTH, 16, number of entries (2..256, need not be a power of two).
- FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through.
- ADDR_WIDTH, clog2(DEPTH), localparam, pointer width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous empty-the-FIFO request.
- w_en  in  1  write request.
- w_data  in  DATA_WIDTH  write data.
- r_en  in  1  read request / head acknowledge (FWFT).
- r_data  out  DATA_WIDTH  read data.
- r_valid  out  1  r_data holds a valid word.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- level  out  ADDR_WIDTH+1  number of stored words.
- af_th  in  ADDR_WIDTH+1  almost-full threshold.
- ae_th  in  ADDR_WIDTH+1  almost-empty threshold.
- almost_full  out  1  level >= af_th.
- almost_empty  out  1  level <= ae_th.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- err_clr  in  1  clears overflow and underflow.

Behaviour:
- Reset (async, active-high, immediate):
  - w_ptr = r_ptr = 0, level = 0.
  - empty = 1, full = 0, almost_full = 0, almost_empty = 1.
  - r_data = 0, r_valid = 0, overflow = underflow = 0.
  - Memory contents are not reset.
- Accept rules:
  - wr_ok = w_en & ~full & ~flush.
  - rd_ok = r_en & ~empty & ~flush.
  - Decisions use registered full/empty only; a write into a full FIFO is rejected even with a simultaneous read.
- Pointer update:
  - wr_ok writes mem[w_ptr] and advances w_ptr.
  - rd_ok advances r_ptr.
  - Pointers wrap from DEPTH-1 to 0 (explicit compare, not bit overflow).
- Level update:
  - level_nxt = level + wr_ok - rd_ok.
  - Simultaneous wr_ok and rd_ok leaves level unchanged.
- Status flags:
  - full, empty, almost_full and almost_empty are registered from level_nxt, so they are valid the cycle after the causing edge.
  - Thresholds are sampled every cycle; changing a threshold takes effect one cycle later.
- FWFT = 0:
  - On rd_ok, r_data <= mem[r_ptr] and r_valid <= 1 for exactly one cycle.
  - Otherwise r_data holds its value and r_valid <= 0.
  - Read latency is 1 cycle.
- FWFT = 1:
  - r_data = mem[r_ptr] whenever ~empty; r_valid = ~empty.
  - rd_ok pops the head; the next word appears the following cycle.
  - Write into an empty FIFO: r_valid rises 1 cycle after the write edge.
- flush:
  - Sets pointers and level to 0, empty = 1, r_valid = 0 on the next edge.
  - Overrides w_en and r_en in the same cycle; these are neither accepted nor flagged.
  - Does not clear overflow or underflow.
- Error flags:
  - overflow is set on w_en & full & ~flush; underflow is set on r_en & empty & ~flush.
  - Both are cleared by err_clr.
  - Set wins over err_clr in the same cycle.
- Threshold edge values:
  - af_th = 0 makes almost_full constant 1.
  - ae_th >= DEPTH makes almost_empty constant 1.
  - Thresholds above DEPTH are legal and need no clamping.
- Reset mid-operation: all outputs return to reset values immediately, independent of clk.

Decomposition:
- Package uart_pkg holds:
  - default UART_FIFO_WIDTH (8) and UART_FIFO_DEPTH (16)
  - the clog2 helper function
  - the FWFT mode constants FIFO_MODE_REG = 0 and FIFO_MODE_FWFT = 1
- Sub-module uart_fifo_mem:
  - DATA_WIDTH x DEPTH register array
  - synchronous write port, asynchronous read port, no reset
- Top level owns pointers, level, flags and the read-data register.

Test Plan:
- Reset, then write 16 words 0x00..0x0F (DEPTH = 16) -> level = 16 and full = 1 one cycle after the last write; almost_full = 1 once level >= af_th = 12.
- Write 0xAA with full = 1 -> word dropped, overflow = 1 and stays set; err_clr pulse -> overflow = 0 next cycle; err_clr together with a new full write -> overflow stays 1.
- FWFT = 0, read 16 words -> r_data = 0x00..0x0F, each with a 1-cycle r_valid pulse 1 cycle after r_en; extra r_en while empty -> underflow = 1, r_data holds 0x0F.
- FWFT = 1, write 0x5A to an empty FIFO -> r_valid = 1 and r_data = 0x5A next cycle, with no r_en needed; r_en -> r_valid = 0 next cycle.
- DEPTH = 12, 40 cycles of simultaneous write/read at level 5 -> level stays 5, pointers wrap 11 -> 0, data order preserved with no loss.
- Mid-stream flush with w_en = r_en = 1 at level 7 -> level = 0, empty = 1, no flags set; async rst mid-burst -> all outputs at reset values before the next clk edge.
